drp_reconf_master: RTL and testbench

DRP initiator driving the `dyn_reconf` responder port (DADDR/DEN/DWE/DI/DO/DRDY) from a simple request/response interface. Each request is one read, one write, or one masked read-modify-write. Writes can optionally hold the PLL in reset and wait for LOCKED, so a DRP reconfiguration runs as a single request. It sits between user/testbench control logic and the PLL model's DRP port.

---
 rtl/drp_pkg.sv | 42 ++++
 rtl/drp_wait_timer.sv | 31 +++
 rtl/drp_reconf_master.sv | 207 ++++++++++++++++++++
 tb/tb_drp_reconf_master.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/drp_pkg.sv
// Shared types and constants for the DRP reconfiguration master.
// Op codes, response error codes, FSM state encoding and the RMW merge helper.
package drp_pkg;

    localparam int unsigned DRP_ADDR_W = 7;
    localparam int unsigned DRP_DATA_W = 16;

    typedef enum logic [1:0] {
        OpRead  = 2'b00,
        OpWrite = 2'b01,
        OpRmw   = 2'b10,
        OpRsvd  = 2'b11
    } drp_op_e;

    typedef enum logic [1:0] {
        ErrOk   = 2'b00,
        ErrDrdy = 2'b01,
        ErrLock = 2'b10
    } drp_err_e;

    typedef enum logic [3:0] {
        StIdle,
        StRstAssert,
        StRdReq,
        StRdWait,
        StWrReq,
        StWrWait,
        StRstRelease,
        StLockWait,
        StResp
    } drp_state_e;

    // Mask bit 1 keeps the old register bit, 0 takes the new data bit.
    function automatic logic [DRP_DATA_W-1:0] rmw_merge(
        input logic [DRP_DATA_W-1:0] old_word,
        input logic [DRP_DATA_W-1:0] new_word,
        input logic [DRP_DATA_W-1:0] keep_mask
    );
        return (old_word & keep_mask) | (new_word & ~keep_mask);
    endfunction

endpackage

// File: rtl/drp_wait_timer.sv
// Saturating wait-cycle counter shared by the DRDY and LOCKED timeouts.
// o_last flags the cycle on which the count of elapsed wait cycles reaches i_limit.
module drp_wait_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W:0]   w_next;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    // The current wait cycle counts too, so compare count+1 against the limit.
    assign w_next = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};
    assign o_last = (w_next >= {1'b0, i_limit});

endmodule

// File: rtl/drp_reconf_master.sv
// DRP initiator: turns one read/write/RMW request into DRP accesses, optionally
// holding the PLL in reset around writes and waiting for lock before responding.
module drp_reconf_master
    import drp_pkg::*;
#(
    parameter int unsigned TIMEOUT      = 1024,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned HOLD_RST     = 1
) (
    input  logic                  i_dclk,
    input  logic                  i_rstn,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [1:0]            i_req_op,
    input  logic [DRP_ADDR_W-1:0] i_req_addr,
    input  logic [DRP_DATA_W-1:0] i_req_data,
    input  logic [DRP_DATA_W-1:0] i_req_mask,
    output logic                  o_resp_valid,
    output logic [DRP_DATA_W-1:0] o_resp_data,
    output logic [1:0]            o_resp_err,
    output logic [DRP_ADDR_W-1:0] o_daddr,
    output logic                  o_den,
    output logic                  o_dwe,
    output logic [DRP_DATA_W-1:0] o_di,
    input  logic [DRP_DATA_W-1:0] i_do,
    input  logic                  i_drdy,
    output logic                  o_pll_rst,
    input  logic                  i_locked
);

    localparam int unsigned MaxLim = (TIMEOUT > LOCK_TIMEOUT) ? TIMEOUT : LOCK_TIMEOUT;
    localparam int unsigned CntW   = $clog2(MaxLim + 1);

    drp_state_e            r_state;
    drp_op_e               r_op;
    logic [DRP_ADDR_W-1:0] r_addr;
    logic [DRP_DATA_W-1:0] r_data;
    logic [DRP_DATA_W-1:0] r_mask;
    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic [DRP_DATA_W-1:0] r_resp_data;
    logic [1:0]            r_resp_err;
    logic [DRP_ADDR_W-1:0] r_daddr;
    logic                  r_den;
    logic                  r_dwe;
    logic [DRP_DATA_W-1:0] r_di;
    logic                  r_pll_rst;

    logic                  w_tmr_clear;
    logic                  w_tmr_en;
    logic [CntW-1:0]       w_limit;
    logic                  w_last;
    logic [DRP_DATA_W-1:0] w_merged;
    drp_op_e               w_req_op;

    always_comb begin
        w_tmr_clear = (r_state == StRdReq) || (r_state == StWrReq) || (r_state == StRstRelease);
        w_tmr_en    = (r_state == StRdWait) || (r_state == StWrWait) || (r_state == StLockWait);
        w_limit     = (r_state == StLockWait) ? CntW'(LOCK_TIMEOUT) : CntW'(TIMEOUT);
        w_merged    = rmw_merge(i_do, r_data, r_mask);
        w_req_op    = (i_req_op == OpRsvd) ? OpRead : drp_op_e'(i_req_op);
    end

    drp_wait_timer #(
        .CNT_W (CntW)
    ) u_timer (
        .i_clk   (i_dclk),
        .i_rstn  (i_rstn),
        .i_clear (w_tmr_clear),
        .i_en    (w_tmr_en),
        .i_limit (w_limit),
        .o_last  (w_last)
    );

    always_ff @(posedge i_dclk) begin
        if (!i_rstn) begin
            r_state      <= StIdle;
            r_op         <= OpRead;
            r_addr       <= '0;
            r_data       <= '0;
            r_mask       <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= ErrOk;
            r_daddr      <= '0;
            r_den        <= 1'b0;
            r_dwe        <= 1'b0;
            r_di         <= '0;
            r_pll_rst    <= 1'b0;
        end else begin
            // DEN/DWE are single-cycle strobes raised only on entry to a REQ state.
            r_den <= 1'b0;
            r_dwe <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_req_ready <= 1'b0;
                        r_op        <= w_req_op;
                        r_addr      <= i_req_addr;
                        r_data      <= i_req_data;
                        r_mask      <= i_req_mask;
                        if ((w_req_op != OpRead) && (HOLD_RST != 0)) begin
                            r_pll_rst <= 1'b1;
                            r_state   <= StRstAssert;
                        end else if (w_req_op == OpWrite) begin
                            r_den   <= 1'b1;
                            r_dwe   <= 1'b1;
                            r_daddr <= i_req_addr;
                            r_di    <= i_req_data;
                            r_state <= StWrReq;
                        end else begin
                            r_den   <= 1'b1;
                            r_daddr <= i_req_addr;
                            r_state <= StRdReq;
                        end
                    end
                end
                StRstAssert: begin
                    r_den   <= 1'b1;
                    r_daddr <= r_addr;
                    if (r_op == OpWrite) begin
                        r_dwe   <= 1'b1;
                        r_di    <= r_data;
                        r_state <= StWrReq;
                    end else begin
                        r_state <= StRdReq;
                    end
                end
                StRdReq: r_state <= StRdWait;
                StRdWait: begin
                    if (i_drdy) begin
                        if (r_op == OpRmw) begin
                            r_den   <= 1'b1;
                            r_dwe   <= 1'b1;
                            r_daddr <= r_addr;
                            r_di    <= w_merged;
                            r_state <= StWrReq;
                        end else begin
                            r_resp_data  <= i_do;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= ErrOk;
                            r_state      <= StResp;
                        end
                    end else if (w_last) begin
                        r_pll_rst    <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= ErrDrdy;
                        r_state      <= StResp;
                    end
                end
                StWrReq: r_state <= StWrWait;
                StWrWait: begin
                    if (i_drdy) begin
                        r_resp_data <= r_di;
                        if (HOLD_RST != 0) begin
                            r_pll_rst <= 1'b0;
                            r_state   <= StRstRelease;
                        end else begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= ErrOk;
                            r_state      <= StResp;
                        end
                    end else if (w_last) begin
                        r_pll_rst    <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= ErrDrdy;
                        r_state      <= StResp;
                    end
                end
                StRstRelease: r_state <= StLockWait;
                StLockWait: begin
                    if (i_locked) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= ErrOk;
                        r_state      <= StResp;
                    end else if (w_last) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= ErrLock;
                        r_state      <= StResp;
                    end
                end
                StResp: begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= ErrOk;
                    r_req_ready  <= 1'b1;
                    r_state      <= StIdle;
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_data  = r_resp_data;
    assign o_resp_err   = r_resp_err;
    assign o_daddr      = r_daddr;
    assign o_den        = r_den;
    assign o_dwe        = r_dwe;
    assign o_di         = r_di;
    assign o_pll_rst    = r_pll_rst;

endmodule

// File: tb/tb_drp_reconf_master.sv
// Directed bench for drp_reconf_master with a behavioural DRP register-file responder.
module tb_drp_reconf_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [6:0]  req_addr;
    logic [15:0] req_data;
    logic [15:0] req_mask;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic [1:0]  resp_err;
    logic [6:0]  daddr;
    logic        den;
    logic        dwe;
    logic [15:0] di;
    logic [15:0] dout = 16'h0;
    logic        drdy = 1'b0;
    logic        pll_rst;
    logic        locked;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    drp_reconf_master #(
        .TIMEOUT      (16),
        .LOCK_TIMEOUT (32),
        .HOLD_RST     (1)
    ) dut (
        .i_dclk       (clk),
        .i_rstn       (rstn),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op),
        .i_req_addr   (req_addr),
        .i_req_data   (req_data),
        .i_req_mask   (req_mask),
        .o_resp_valid (resp_valid),
        .o_resp_data  (resp_data),
        .o_resp_err   (resp_err),
        .o_daddr      (daddr),
        .o_den        (den),
        .o_dwe        (dwe),
        .o_di         (di),
        .i_do         (dout),
        .i_drdy       (drdy),
        .o_pll_rst    (pll_rst),
        .i_locked     (locked)
    );

    // Responder: DRDY one cycle after DEN unless muted.
    logic [15:0] mem [0:127];
    logic        mute = 1'b0;
    int          rd_pulses = 0;
    int          wr_pulses = 0;
    int          resp_cnt = 0;
    logic        wr_pll = 1'b0;
    logic [15:0] last_di = 16'h0;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        drdy <= 1'b0;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
        if (den) begin
            if (dwe) begin
                wr_pulses <= wr_pulses + 1;
                last_di   <= di;
                wr_pll    <= pll_rst;
                if (!mute) mem[daddr] <= di;
            end else begin
                rd_pulses <= rd_pulses + 1;
                if (!mute) dout <= mem[daddr];
            end
            if (!mute) drdy <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request from a negedge; return response fields and latency in edges.
    task automatic request(input logic [1:0] op, input logic [6:0] addr,
                           input logic [15:0] data, input logic [15:0] mask,
                           output logic [15:0] rdata, output logic [1:0] rerr,
                           output int lat, output logic pll_at_resp, output logic ok);
        int acc;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_data  = data;
        req_mask  = mask;
        @(negedge clk);
        req_valid = 1'b0;
        acc       = cyc;
        check("ready_low_after_accept", {31'd0, req_ready}, 32'd0);
        ok = 1'b0;
        rdata = 16'h0;
        rerr = 2'b11;
        lat = 0;
        pll_at_resp = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (resp_valid) begin
                ok          = 1'b1;
                rdata       = resp_data;
                rerr        = resp_err;
                lat         = cyc - acc + 1;
                pll_at_resp = pll_rst;
                check("ready_low_in_resp", {31'd0, req_ready}, 32'd0);
                break;
            end
            @(negedge clk);
        end
        check("resp_seen", {31'd0, ok}, 32'd1);
        @(negedge clk);
        check("idle_after_resp", {29'd0, req_ready, resp_valid, |resp_err}, 32'd4);
    endtask

    logic [15:0] rdata;
    logic [1:0]  rerr;
    int          lat;
    logic        prst;
    logic        ok;
    int          r0;
    int          w0;
    int          c0;
    logic [15:0] reg8;

    initial begin
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_addr  = 7'h0;
        req_data  = 16'h0;
        req_mask  = 16'h0;
        locked    = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_ctl", {25'd0, req_ready, den, dwe, resp_valid, resp_err, pll_rst},
              32'h40);
        check("reset_daddr_di", {9'd0, daddr, di}, 32'd0);
        check("reset_resp_data", {16'd0, resp_data}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Write 0x6183 to CLKOUT0 ClkReg1: high 6 + low 3 = divide 9.
        r0 = rd_pulses; w0 = wr_pulses;
        request(2'b01, 7'h08, 16'h6183, 16'h0000, rdata, rerr, lat, prst, ok);
        check("wr_resp_data", {16'd0, rdata}, 32'h6183);
        check("wr_resp_err", {30'd0, rerr}, 32'd0);
        check("wr_latency", lat, 32'd6);
        check("wr_den_pulses", {wr_pulses - w0, rd_pulses - r0}, {32'd1, 32'd0});
        check("wr_pll_rst_at_den", {31'd0, wr_pll}, 32'd1);
        reg8 = mem[8];
        check("clkout0_divide", {26'd0, reg8[11:6]} + {26'd0, reg8[5:0]}, 32'd9);

        request(2'b01, 7'h09, 16'hFFFF, 16'h0000, rdata, rerr, lat, prst, ok);
        check("preload_resp", {14'd0, rerr, rdata}, 32'h0000FFFF);

        r0 = rd_pulses; w0 = wr_pulses;
        request(2'b10, 7'h09, 16'h0043, 16'hFF00, rdata, rerr, lat, prst, ok);
        check("rmw_resp_data", {16'd0, rdata}, 32'hFF43);
        check("rmw_resp_err", {30'd0, rerr}, 32'd0);
        check("rmw_pulses", {wr_pulses - w0, rd_pulses - r0}, {32'd1, 32'd1});
        check("rmw_di", {16'd0, last_di}, 32'hFF43);
        check("rmw_latency", lat, 32'd8);

        r0 = rd_pulses; w0 = wr_pulses;
        request(2'b00, 7'h08, 16'h0000, 16'h0000, rdata, rerr, lat, prst, ok);
        check("rd_resp_data", {16'd0, rdata}, 32'h6183);
        check("rd_resp_err", {30'd0, rerr}, 32'd0);
        check("rd_latency", lat, 32'd3);
        check("rd_pulses", {wr_pulses - w0, rd_pulses - r0}, {32'd0, 32'd1});

        // Reserved op behaves as a read.
        request(2'b11, 7'h09, 16'h1111, 16'h0000, rdata, rerr, lat, prst, ok);
        check("rsvd_as_read", {14'd0, rerr, rdata}, 32'h0000FF43);

        mute = 1'b1;
        r0 = rd_pulses; w0 = wr_pulses;
        request(2'b00, 7'h05, 16'h0000, 16'h0000, rdata, rerr, lat, prst, ok);
        check("rd_tmo_err", {30'd0, rerr}, 32'd1);
        check("rd_tmo_latency", lat, 32'd18);
        check("rd_tmo_den_pulses", {wr_pulses - w0, rd_pulses - r0}, {32'd0, 32'd1});

        r0 = rd_pulses; w0 = wr_pulses;
        request(2'b01, 7'h0A, 16'h1234, 16'h0000, rdata, rerr, lat, prst, ok);
        check("wr_tmo_err", {30'd0, rerr}, 32'd1);
        check("wr_tmo_pll_rst", {31'd0, prst}, 32'd0);
        check("wr_tmo_latency", lat, 32'd19);
        check("wr_tmo_den_pulses", {wr_pulses - w0, rd_pulses - r0}, {32'd1, 32'd0});
        mute = 1'b0;

        locked = 1'b0;
        request(2'b01, 7'h0B, 16'h00AA, 16'h0000, rdata, rerr, lat, prst, ok);
        check("lock_tmo_err", {30'd0, rerr}, 32'd2);
        check("lock_tmo_data", {16'd0, rdata}, 32'h00AA);
        check("lock_tmo_latency", lat, 32'd37);
        locked = 1'b1;

        // Abort a write stuck in WR_WAIT with a one-cycle reset pulse.
        mute      = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_addr  = 7'h0C;
        req_data  = 16'h5555;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_den", {30'd0, den, dwe}, 32'd3);
        @(negedge clk);
        check("abort_pll_pre", {31'd0, pll_rst}, 32'd1);
        rstn = 1'b0;
        c0   = resp_cnt;
        @(negedge clk);
        check("abort_state", {29'd0, pll_rst, den, req_ready}, 32'd1);
        rstn = 1'b1;
        mute = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_no_resp", resp_cnt - c0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
